moore_checker: RTL

- Self-checking monitor for the small configurable Moore-machine blocks, such as 2-state and 3-state FSMs under test.
- Holds a programmable transition/output table, steps a golden model in lockstep with the DUT's ctrl_in enable, and compares the DUT's registered state/out after every step.
- Sits beside the DUT in the bench or on the board. It flags the first mismatch and halts so the failing step can be read back.

---
 rtl/moore_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/moore_checker.sv
// Golden-model monitor for small Moore FSMs: steps a programmable transition table
// alongside the DUT and halts on the first state/output disagreement.
module moore_checker #(
  parameter int NUM_STATES = 2,
  parameter int STATE_W    = 3,
  parameter int SW_W       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [SW_W-1:0]    cfg_sw,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_out,
  input  logic [STATE_W-1:0] cfg_init,
  input  logic               start,
  input  logic               stop,
  input  logic [SW_W-1:0]    sw_in,
  input  logic               ctrl_in,
  input  logic [STATE_W-1:0] dut_state,
  input  logic               dut_out,
  output logic               running,
  output logic               err,
  output logic               err_sticky,
  output logic               tbl_err,
  output logic [STATE_W-1:0] exp_state,
  output logic               exp_out,
  output logic [15:0]        step_cnt,
  output logic [15:0]        err_step
);

  localparam int NUM_ENT = NUM_STATES * (1 << SW_W);
  localparam int IDX_W   = STATE_W + SW_W;
  localparam logic [STATE_W:0] NS_LIM = (STATE_W+1)'(NUM_STATES);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nxt;

  logic [NUM_ENT-1:0]              tbl_vld, tbl_out;
  logic [NUM_ENT-1:0][STATE_W-1:0] tbl_next;

  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               wr_en;
  logic               ent_vld, ent_out;
  logic [STATE_W-1:0] ent_next;
  logic               chk_pend;
  logic               do_start, do_step, mis, bad_ent;

  // {state, sw} concatenation is exactly state*2^SW_W + sw
  assign wr_idx = {cfg_state, cfg_sw};
  assign rd_idx = {exp_state, sw_in};
  assign wr_en  = cfg_we && (state != RUN) &&
                  ({1'b0, cfg_state} < NS_LIM) && ({1'b0, cfg_next} < NS_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_vld  <= '0;
      tbl_out  <= '0;
      tbl_next <= '0;
    end else if (wr_en) begin
      for (int e = 0; e < NUM_ENT; e++) begin
        if (wr_idx == IDX_W'(e)) begin
          tbl_vld[e]  <= 1'b1;
          tbl_out[e]  <= cfg_out;
          tbl_next[e] <= cfg_next;
        end
      end
    end
  end

  // Out-of-range model state never matches an entry, so it reads as unprogrammed
  always_comb begin
    ent_vld  = 1'b0;
    ent_out  = 1'b0;
    ent_next = '0;
    for (int e = 0; e < NUM_ENT; e++) begin
      if (rd_idx == IDX_W'(e)) begin
        ent_vld  = tbl_vld[e];
        ent_out  = tbl_out[e];
        ent_next = tbl_next[e];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_step   = 1'b0;
    mis       = 1'b0;
    bad_ent   = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start && !stop) begin
          state_nxt = RUN;
          do_start  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          // compare sees the previous step's values even if a new step lands now
          mis = chk_pend && ((dut_state != exp_state) || (dut_out != exp_out));
          if (ctrl_in) begin
            if (ent_vld) do_step = 1'b1;
            else         bad_ent = 1'b1;
          end
          if (mis || bad_ent) state_nxt = HALT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
      tbl_err    <= 1'b0;
      exp_state  <= '0;
      exp_out    <= 1'b0;
      step_cnt   <= '0;
      err_step   <= '0;
      chk_pend   <= 1'b0;
    end else begin
      err      <= mis;
      chk_pend <= do_step && (state_nxt == RUN);
      if (do_start) begin
        exp_state  <= cfg_init;
        exp_out    <= 1'b0;
        step_cnt   <= '0;
        err_step   <= '0;
        err_sticky <= 1'b0;
        tbl_err    <= 1'b0;
      end else begin
        if (do_step) begin
          exp_state <= ent_next;
          exp_out   <= ent_out;
          step_cnt  <= (step_cnt == 16'hFFFF) ? step_cnt : step_cnt + 16'd1;
        end
        if (mis) begin
          err_sticky <= 1'b1;
          err_step   <= step_cnt;
        end
        if (bad_ent) tbl_err <= 1'b1;
      end
    end
  end

  assign running = (state == RUN);

endmodule
